tmds_channel_decoder: RTL and testbench
=======================================

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 The module SHALL have parameter C_lock_tokens, default 16: consecutive control tokens required to declare lock.
REQ-002 The module SHALL have parameter C_hunt_timeout, default 4096: cycles without a qualifying control-token run before slip (HUNT) or unlock (LOCKED).
REQ-003 The module SHALL have parameter C_slip_wait, default 16: settle cycles after a bitslip request.
REQ-004 The module SHALL have port clk_pixel, input, 1 bit: pixel clock, the only clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port in_symbol, input, 10 bits: deserialized TMDS word; bit 0 is transmitted first.
REQ-007 The module SHALL have port out_bitslip, output, 1 bit: one-cycle pulse requesting the deserializer to shift word alignment by one bit.
REQ-008 The module SHALL have port out_data, output, 8 bits: decoded pixel byte.
REQ-009 The module SHALL have port out_c, output, 2 bits: control bits {c1,c0} (hsync/vsync on the blue channel).
REQ-010 The module SHALL have port out_de, output, 1 bit: data enable (active video).
REQ-011 The module SHALL have port out_locked, output, 1 bit: word alignment achieved.

Function
REQ-012 in_symbol SHALL be registered once, then classified and decoded into the output registers, giving a fixed latency of 2 clk_pixel cycles from in_symbol to out_data/out_c/out_de.
REQ-013 Control tokens SHALL be recognised as: 10'h354 -> c=00; 10'h0AB -> c=01; 10'h154 -> c=10; 10'h2AB -> c=11; every other word is a data word.
REQ-014 Data decode SHALL first form d = sym[9] ? ~sym[7:0] : sym[7:0].
REQ-015 Data decode SHALL then set out[0]=d[0] and, for i=1..7, out[i] = d[i]^d[i-1] when sym[8]=1, else ~(d[i]^d[i-1]).
REQ-016 While LOCKED, a control token SHALL drive out_de=0, out_data=8'h00, and out_c=decoded value.
REQ-017 While LOCKED, a data word SHALL drive out_de=1 and out_data=decoded value, with out_c holding its last value.
REQ-018 While not LOCKED, outputs SHALL be forced to out_de=0, out_data=8'h00, out_c=2'b00.
REQ-019 The FSM SHALL have the states HUNT, SLIP, WAIT, and LOCKED, with a token-run counter (run) and a timeout counter (tmo).
REQ-020 In HUNT, a control token SHALL increment run (saturating) and a data word SHALL clear run; tmo increments every cycle.
REQ-021 In HUNT, run reaching C_lock_tokens SHALL cause a transition to LOCKED, clearing tmo; lock takes precedence if it coincides with timeout in the same cycle.
REQ-022 In HUNT, tmo reaching C_hunt_timeout-1 without lock SHALL cause a transition to SLIP.
REQ-023 SLIP SHALL assert out_bitslip for exactly one cycle, then go to WAIT.
REQ-024 WAIT SHALL count C_slip_wait cycles ignoring input, then go to HUNT with run and tmo cleared.
REQ-025 In LOCKED, each completed run of C_lock_tokens consecutive control tokens SHALL clear tmo.
REQ-026 In LOCKED, tmo reaching C_hunt_timeout-1 SHALL cause a transition to HUNT with out_locked=0 and run cleared; no bitslip is issued on unlock.
REQ-027 out_locked SHALL equal 1 exactly while the state is LOCKED, registered, and take effect in the cycle the state changes.
REQ-028 Bitslip requests SHALL be unbounded; the deserializer wraps modulo 10, so the decoder keeps no slip count.
REQ-029 Counters SHALL be sized to hold their parameter value without overflow.

Reset
REQ-030 reset_n=0 sampled on a clk_pixel edge SHALL set state=HUNT and run=tmo=0.
REQ-031 Reset SHALL set out_bitslip=0, out_data=8'h00, out_c=2'b00, out_de=0, out_locked=0, and clear the pipeline registers.
REQ-032 Reset asserted mid-operation (any state, including SLIP) SHALL abort it in the same edge; a pending bitslip pulse SHALL NOT be emitted.

Verification
REQ-033 Lock: 20 x 10'h354 -> out_locked rises 1 cycle after the 16th token is classified; out_de=0, out_c=00, out_bitslip never asserted.
REQ-034 Data decode while locked: 10'h100 -> 8'h00; 10'h1FF -> 8'h01; 10'h2FF -> 8'hFE; each with out_de=1 exactly 2 cycles after input.
REQ-035 Control decode while locked: 10'h0AB, 10'h154, 10'h2AB -> out_c = 01, 10, 11 with out_de=0 and out_data=8'h00.
REQ-036 Misaligned stream (valid DVI line rotated by 3 bits) -> a single-cycle out_bitslip every 4096+1+16 cycles until the bench rotates back; lock is then achieved within the next line.
REQ-037 Loss of lock: while locked, feed 4096 data words -> out_locked falls at the timeout, outputs go to 0, and out_bitslip is not asserted.
REQ-038 Reset mid-SLIP: reset_n=0 in the SLIP cycle -> out_bitslip stays 0, all outputs are 0, and the state is HUNT after release.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel decoder with control-token word-alignment FSM
module tmds_channel_decoder #(
    parameter int C_lock_tokens  = 16,
    parameter int C_hunt_timeout = 4096,
    parameter int C_slip_wait    = 16
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] in_symbol,
    output logic       out_bitslip,
    output logic [7:0] out_data,
    output logic [1:0] out_c,
    output logic       out_de,
    output logic       out_locked
);

    localparam int RUN_W   = $clog2(C_lock_tokens + 1);
    localparam int TMO_LIM = (C_hunt_timeout > C_slip_wait) ? C_hunt_timeout : C_slip_wait;
    localparam int TMO_W   = $clog2(TMO_LIM + 1);

    localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(C_lock_tokens);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(C_lock_tokens - 1);
    localparam logic [TMO_W-1:0] HUNT_LAST = TMO_W'(C_hunt_timeout - 1);
    localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(C_slip_wait - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED
    } state_t;

    state_t           state, state_nx;
    logic [9:0]       sym_q;
    logic [RUN_W-1:0] run, run_nx;
    logic [TMO_W-1:0] tmo, tmo_nx;
    logic             is_ctrl;
    logic [1:0]       ctrl_c;
    logic [7:0]       d;
    logic [7:0]       dec;

    always_comb begin
        is_ctrl = 1'b1;
        ctrl_c  = 2'b00;
        case (sym_q)
            10'h354: ctrl_c = 2'b00;
            10'h0AB: ctrl_c = 2'b01;
            10'h154: ctrl_c = 2'b10;
            10'h2AB: ctrl_c = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    // Undo the transmitter's optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        d      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = 8'h00;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        state_nx = state;
        run_nx   = run;
        tmo_nx   = tmo;
        case (state)
            ST_HUNT: begin
                if (run == RUN_FULL) begin
                    state_nx = ST_LOCKED;
                    run_nx   = '0;
                    tmo_nx   = '0;
                end else if (tmo == HUNT_LAST) begin
                    state_nx = ST_SLIP;
                    run_nx   = '0;
                    tmo_nx   = '0;
                end else begin
                    tmo_nx = tmo + 1'b1;
                    run_nx = is_ctrl ? run + 1'b1 : '0;
                end
            end
            ST_SLIP: begin
                state_nx = ST_WAIT;
                tmo_nx   = '0;
            end
            ST_WAIT: begin
                if (tmo == WAIT_LAST) begin
                    state_nx = ST_HUNT;
                    run_nx   = '0;
                    tmo_nx   = '0;
                end else begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (tmo == HUNT_LAST) begin
                    state_nx = ST_HUNT;
                    run_nx   = '0;
                    tmo_nx   = '0;
                end else begin
                    tmo_nx = tmo + 1'b1;
                    if (!is_ctrl) begin
                        run_nx = '0;
                    end else if (run == RUN_LAST) begin
                        // A full token run proves alignment is still good.
                        run_nx = '0;
                        tmo_nx = '0;
                    end else begin
                        run_nx = run + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_HUNT;
                run_nx   = '0;
                tmo_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state       <= ST_HUNT;
            sym_q       <= '0;
            run         <= '0;
            tmo         <= '0;
            out_bitslip <= 1'b0;
            out_locked  <= 1'b0;
            out_data    <= 8'h00;
            out_c       <= 2'b00;
            out_de      <= 1'b0;
        end else begin
            state       <= state_nx;
            sym_q       <= in_symbol;
            run         <= run_nx;
            tmo         <= tmo_nx;
            // Pulse follows the SLIP cycle so a reset during SLIP suppresses it.
            out_bitslip <= (state == ST_SLIP);
            out_locked  <= (state_nx == ST_LOCKED);
            if (state_nx == ST_LOCKED) begin
                if (is_ctrl) begin
                    out_de   <= 1'b0;
                    out_data <= 8'h00;
                    out_c    <= ctrl_c;
                end else begin
                    out_de   <= 1'b1;
                    out_data <= dec;
                end
            end else begin
                out_de   <= 1'b0;
                out_data <= 8'h00;
                out_c    <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - self-checking bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

    localparam int LOCK_N = 16;
    localparam int TMO_N  = 4096;
    localparam int WAIT_N = 16;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b0;
    logic [9:0] in_symbol = 10'h000;
    logic       out_bitslip;
    logic [7:0] out_data;
    logic [1:0] out_c;
    logic       out_de;
    logic       out_locked;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b1;

    tmds_channel_decoder dut (
        .clk_pixel  (clk_pixel),
        .reset_n    (reset_n),
        .in_symbol  (in_symbol),
        .out_bitslip(out_bitslip),
        .out_data   (out_data),
        .out_c      (out_c),
        .out_de     (out_de),
        .out_locked (out_locked)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int tok_code(input int w);
        case (w)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int ref_decode(input int w);
        int dd, r, x;
        dd = w % 256;
        if ((w / 512) % 2 == 1) dd = 255 - dd;
        r = dd % 2;
        for (int i = 1; i < 8; i++) begin
            x = ((dd >> i) % 2 == (dd >> (i - 1)) % 2) ? 0 : 1;
            if ((w / 256) % 2 == 0) x = 1 - x;
            r = r + x * (1 << i);
        end
        return r;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (tok_code(int'(w)) >= 0);
        return w;
    endfunction

    // Behavioural reference: locked flag, pending slip, countdown of settle cycles,
    // age since last good token run, and length of the current token run.
    int         m_prev = 0;
    bit         m_locked = 0, m_slip_pending = 0;
    int         m_wait_left = 0, m_age = 0, m_tokens = 0;
    logic [7:0] e_data = 0;
    logic [1:0] e_c = 0;
    logic       e_de = 0, e_bitslip = 0, e_locked = 0;

    always @(posedge clk_pixel) begin : ref_model
        int cls;
        cls = tok_code(m_prev);
        if (!reset_n) begin
            m_prev = 0; m_locked = 0; m_slip_pending = 0;
            m_wait_left = 0; m_age = 0; m_tokens = 0;
            e_data = 0; e_c = 0; e_de = 0; e_bitslip = 0; e_locked = 0;
        end else begin
            e_bitslip = 0;
            if (m_locked) begin
                if (m_age == TMO_N - 1) begin
                    m_locked = 0; m_age = 0; m_tokens = 0;
                end else begin
                    m_age++;
                    if (cls >= 0) begin
                        m_tokens++;
                        if (m_tokens == LOCK_N) begin m_tokens = 0; m_age = 0; end
                    end else m_tokens = 0;
                end
            end else if (m_slip_pending) begin
                m_slip_pending = 0; e_bitslip = 1; m_wait_left = WAIT_N;
            end else if (m_wait_left > 0) begin
                m_wait_left--;
                if (m_wait_left == 0) begin m_age = 0; m_tokens = 0; end
            end else if (m_tokens >= LOCK_N) begin
                m_locked = 1; m_age = 0; m_tokens = 0;
            end else if (m_age == TMO_N - 1) begin
                m_slip_pending = 1; m_age = 0; m_tokens = 0;
            end else begin
                m_age++;
                m_tokens = (cls >= 0) ? m_tokens + 1 : 0;
            end
            e_locked = m_locked;
            if (m_locked && cls >= 0) begin
                e_de = 0; e_data = 0; e_c = 2'(cls);
            end else if (m_locked) begin
                e_de = 1; e_data = 8'(ref_decode(m_prev));
            end else begin
                e_de = 0; e_data = 0; e_c = 0;
            end
            m_prev = int'(in_symbol);
        end
    end

    always @(negedge clk_pixel) begin
        if (chk_en)
            check("model", {out_locked, out_bitslip, out_de, out_c, out_data},
                  {e_locked, e_bitslip, e_de, e_c, e_data});
    end

    typedef struct {
        logic [9:0] sym;
        logic [7:0] data;
        logic [1:0] c;
        logic       de;
    } vec_t;

    vec_t tbl[10];

    task automatic do_reset();
        reset_n   = 1'b0;
        in_symbol = 10'h000;
        repeat (3) @(negedge clk_pixel);
        reset_n = 1'b1;
    endtask

    // Locks from a freshly released HUNT: out_locked must rise on the 18th negedge.
    task automatic lock_seq(input string tag);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk_pixel);
            check({tag, "_lock"}, {out_locked, out_bitslip, out_de, out_c},
                  (i >= 18) ? 5'b10000 : 5'b00000);
            in_symbol = 10'h354;
        end
    endtask

    initial begin
        tbl[0] = '{10'h354, 8'h00, 2'b00, 1'b0};
        tbl[1] = '{10'h100, 8'h00, 2'b00, 1'b1};
        tbl[2] = '{10'h1FF, 8'h01, 2'b00, 1'b1};
        tbl[3] = '{10'h2FF, 8'hFE, 2'b00, 1'b1};
        tbl[4] = '{10'h0AB, 8'h00, 2'b01, 1'b0};
        tbl[5] = '{10'h154, 8'h00, 2'b10, 1'b0};
        tbl[6] = '{10'h2AB, 8'h00, 2'b11, 1'b0};
        tbl[7] = '{10'h1FF, 8'h01, 2'b11, 1'b1};
        tbl[8] = '{10'h0F0, 8'hEE, 2'b11, 1'b1};
        tbl[9] = '{10'h354, 8'h00, 2'b00, 1'b0};

        reset_n   = 1'b0;
        in_symbol = 10'h3FF;
        repeat (3) @(negedge clk_pixel);
        check("reset_outs", {out_locked, out_bitslip, out_de, out_c, out_data}, 0);
        in_symbol = 10'h000;
        reset_n   = 1'b1;

        lock_seq("first");

        for (int i = 0; i < 12; i++) begin
            @(negedge clk_pixel);
            if (i >= 2)
                check($sformatf("vec%0d", i - 2), {out_de, out_c, out_data},
                      {tbl[i-2].de, tbl[i-2].c, tbl[i-2].data});
            in_symbol = (i < 10) ? tbl[i].sym : 10'h354;
        end

        // Random traffic: token bursts keep lock alive, data halves carry stray tokens.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_pixel);
            if (i % 40 < 20) begin
                case ($urandom_range(0, 3))
                    0: in_symbol = 10'h354;
                    1: in_symbol = 10'h0AB;
                    2: in_symbol = 10'h154;
                    default: in_symbol = 10'h2AB;
                endcase
            end else if ($urandom_range(0, 7) == 0) begin
                in_symbol = 10'h0AB;
            end else begin
                in_symbol = rand_data();
            end
        end
        check("rand_locked", out_locked, 1);

        begin : unlock_phase
            int fall = -1;
            bit seen = 0;
            for (int k = 0; k < 5000; k++) begin
                @(negedge clk_pixel);
                if (out_bitslip) seen = 1;
                if (!out_locked) begin fall = k; break; end
                in_symbol = rand_data();
            end
            check("unlock_seen", int'(fall >= 0), 1);
            check("unlock_not_early", int'(fall > 4000), 1);
            check("unlock_bitslip", seen, 0);
            check("unlock_outs", {out_de, out_c, out_data}, 0);
        end

        begin : reset_in_slip
            int hit = 0;
            for (int k = 0; k < 6000; k++) begin
                @(negedge clk_pixel);
                if (m_slip_pending) begin hit = 1; break; end
                in_symbol = rand_data();
            end
            check("slip_reached", hit, 1);
            reset_n = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk_pixel);
                check("rst_slip_outs", {out_locked, out_bitslip, out_de, out_c, out_data}, 0);
            end
            in_symbol = 10'h000;
            reset_n   = 1'b1;
            lock_seq("after_slip_rst");
        end

        begin : misalign
            int offset = 3, pos = 0, nslip = 0, last_slip = -1, lock_cyc = -1;
            logic [9:0]  cur, nxt;
            logic [19:0] pair;
            do_reset();
            cur = 10'h354;
            nxt = 10'h354;
            pos = 2;
            for (int cyc = 0; cyc < 40000; cyc++) begin
                @(negedge clk_pixel);
                if (out_locked) begin lock_cyc = cyc; break; end
                if (out_bitslip) begin
                    offset = (offset + 1) % 10;
                    nslip++;
                    if (last_slip >= 0) check("slip_period", cyc - last_slip, 4113);
                    last_slip = cyc;
                end
                pair      = {nxt, cur};
                pair      = pair >> offset;
                in_symbol = pair[9:0];
                cur       = nxt;
                nxt       = (pos < 100) ? 10'h354 : rand_data();
                pos       = (pos + 1) % 300;
            end
            check("misalign_lock", int'(lock_cyc >= 0), 1);
            check("slip_count", nslip, 7);
            check("final_offset", offset, 0);
            check("lock_within_line", int'(lock_cyc - last_slip < 340), 1);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
